// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types for the debounce controller and its channels.
package debounce_pkg;
  localparam int CNT_W = 4;
  typedef enum logic {IDLE, PRESENT} arb_state_t;
  typedef struct packed {
    logic [3:0] ch;
    logic       rise;
  } debounce_event_t;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: two-flop synchroniser, tick-sampled stability counter and debounced level with edge pulse.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   STABLE_CNT = 4,
  parameter logic IDLE       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_edge
);
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             w_diff;
  logic             w_flip;
  assign w_diff  = r_sync[1] ^ r_level;
  assign w_flip  = i_tick & w_diff & (r_cnt == CNT_W'(STABLE_CNT - 1));
  assign o_edge  = w_flip;
  assign o_level = r_level;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= {2{IDLE}};
      r_cnt   <= '0;
      r_level <= IDLE;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (i_tick) begin
        r_cnt <= (!w_diff || w_flip) ? '0 : r_cnt + 1'b1;
        if (w_flip) r_level <= ~r_level;
      end
    end
  end
endmodule

// File: rtl/debounce_ctrl.sv
// debounce_ctrl: per-channel debounce plus round-robin event serialiser with irq.
// Optional overrun tracking enabled by defining DEBOUNCE_CTRL_OVERRUN_EN.
module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int                N_CH       = 4,
  parameter logic [31:0]       TICK_DIV   = 32'h000fffff,
  parameter int                STABLE_CNT = 4,
  parameter logic [N_CH-1:0]   IDLE_LEVEL = '0,
  localparam int               CH_W       = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [CH_W-1:0] ev_ch,
  output logic            ev_rise,
  output logic            irq,
  output logic [N_CH-1:0] overrun,
  input  logic [N_CH-1:0] ovr_clr
);
  logic [31:0]     r_tick_cnt;
  logic            w_tick;
  logic [N_CH-1:0] w_edge;
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] r_pol;
  logic [N_CH-1:0] w_clr;
  logic [3:0]      r_rr;
  logic [CH_W-1:0] w_k;
  logic            w_found;
  arb_state_t      r_state;
  debounce_event_t r_ev;
  debounce_event_t w_sel;
  assign w_tick   = r_tick_cnt == TICK_DIV - 32'd1;
  assign ev_valid = r_state == PRESENT;
  assign ev_ch    = r_ev.ch[CH_W-1:0];
  assign ev_rise  = r_ev.rise;
  assign irq      = |r_pending | ev_valid;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tick_cnt <= '0;
    else r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 32'd1;
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    debounce_ch #(.STABLE_CNT(STABLE_CNT), .IDLE(IDLE_LEVEL[c])) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_tick (w_tick),
      .i_raw  (raw_in[c]),
      .o_level(level_out[c]),
      .o_edge (w_edge[c])
    );
  end
  // first pending channel at or after the rr pointer, wrapping; only loaded in IDLE
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_clr   = '0;
    w_k     = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_k = CH_W'((int'(r_rr) + i) % N_CH);
      if (!w_found && r_pending[w_k]) begin
        w_found    = 1'b1;
        w_sel.ch   = 4'(w_k);
        w_sel.rise = r_pol[w_k];
        w_clr[w_k] = r_state == IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_pol     <= '0;
      r_rr      <= '0;
      r_ev      <= '0;
      r_state   <= IDLE;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_pol     <= (r_pol & ~w_edge) | (w_edge & ~level_out);
      if (r_state == IDLE && w_found) begin
        r_ev    <= w_sel;
        r_state <= PRESENT;
      end else if (r_state == PRESENT && ev_ready) begin
        r_state <= IDLE;
        r_rr    <= (r_ev.ch == 4'(N_CH - 1)) ? '0 : r_ev.ch + 4'd1;
      end
    end
  end
`ifdef DEBOUNCE_CTRL_OVERRUN_EN
  logic [N_CH-1:0] r_ovr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ovr <= '0;
    else r_ovr <= (r_ovr & ~ovr_clr) | (w_edge & r_pending & ~w_clr);
  end
  assign overrun = r_ovr;
`else
  logic w_unused;
  assign w_unused = ^ovr_clr;
  assign overrun  = '0;
`endif
endmodule

// File: tb/tb_debounce_ctrl.sv
// tb_debounce_ctrl: directed checks of debounce, arbitration, overrun and async reset.
module tb_debounce_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] raw_in = '0;
  logic [3:0] level_out;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [1:0] ev_ch;
  logic       ev_rise;
  logic       irq;
  logic [3:0] overrun;
  logic [3:0] ovr_clr = '0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [2:0] ev_q[$];
`ifdef DEBOUNCE_CTRL_OVERRUN_EN
  localparam logic [3:0] OVR_EXP = 4'b0100;
`else
  localparam logic [3:0] OVR_EXP = 4'b0000;
`endif

  debounce_ctrl #(.N_CH(4), .TICK_DIV(32'd4), .STABLE_CNT(3), .IDLE_LEVEL(4'b0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (raw_in),
    .level_out(level_out),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ch    (ev_ch),
    .ev_rise  (ev_rise),
    .irq      (irq),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst && ev_valid && ev_ready) ev_q.push_back({ev_ch, ev_rise});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!ev_valid && n < 24) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(ev_valid), 1);
  endtask

  initial begin
    int n;
    int bad;
    #1;
    chk("rst_level", 32'(level_out), 0);
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_ev", 32'({ev_ch, ev_rise}), 0);
    @(negedge clk);
    rst = 1'b1;
    ev_ready = 1'b1;
    // single rising edge on ch1
    raw_in[1] = 1'b1;
    n = 0;
    while (!level_out[1] && n < 18) begin
      @(negedge clk);
      n++;
    end
    chk("t1_level", 32'(level_out[1]), 1);
    chk("t1_irq_pend", 32'(irq), 1);
    chk("t1_valid_lat", 32'(ev_valid), 0);
    @(negedge clk);
    chk("t1_valid", 32'(ev_valid), 1);
    chk("t1_ev", 32'({ev_ch, ev_rise}), 32'(3'b011));
    @(negedge clk);
    chk("t1_valid_drop", 32'(ev_valid), 0);
    chk("t1_irq_drop", 32'(irq), 0);
    repeat (30) @(negedge clk);
    chk("t1_count", 32'(ev_q.size()), 1);
    raw_in[1] = 1'b0;
    repeat (25) @(negedge clk);
    chk("t1_fall_count", 32'(ev_q.size()), 2);
    chk("t1_fall_ev", 32'(ev_q[1]), 32'(3'b010));
    chk("t1_fall_level", 32'(level_out), 0);
    // 2-tick glitch on ch2 is rejected
    bad = 0;
    raw_in[2] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      bad += int'(irq);
    end
    raw_in[2] = 1'b0;
    repeat (30) begin
      @(negedge clk);
      bad += int'(irq | ev_valid);
    end
    chk("t2_level", 32'(level_out), 0);
    chk("t2_irq", 32'(bad), 0);
    chk("t2_count", 32'(ev_q.size()), 2);
    // fresh reset so the rr pointer starts at 0
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ev_q.delete();
    raw_in = 4'b1001;
    repeat (25) @(negedge clk);
    chk("t3_count", 32'(ev_q.size()), 2);
    chk("t3_first", 32'(ev_q[0]), 32'(3'b001));
    chk("t3_second", 32'(ev_q[1]), 32'(3'b111));
    chk("t3_level", 32'(level_out), 32'(4'b1001));
    raw_in = 4'b0000;
    repeat (25) @(negedge clk);
    chk("t3_wrap_count", 32'(ev_q.size()), 4);
    chk("t3_wrap_first", 32'(ev_q[2]), 32'(3'b000));
    chk("t3_wrap_second", 32'(ev_q[3]), 32'(3'b110));
    // ch0 parked in PRESENT while ch2 rises then falls behind it
    ev_ready = 1'b0;
    ev_q.delete();
    raw_in[0] = 1'b1;
    wait_valid("t4_valid");
    chk("t4_ev", 32'({ev_ch, ev_rise}), 32'(3'b001));
    bad = 0;
    raw_in[2] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      bad += int'({ev_valid, ev_ch, ev_rise} != 4'b1001);
    end
    raw_in[2] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      bad += int'({ev_valid, ev_ch, ev_rise} != 4'b1001);
    end
    chk("t5_hold", 32'(bad), 0);
    chk("t4_level", 32'(level_out), 32'(4'b0001));
    chk("t4_irq", 32'(irq), 1);
    chk("t4_ovr", 32'(overrun), 32'(OVR_EXP));
    ovr_clr = 4'b0100;
    @(negedge clk);
    ovr_clr = 4'b0000;
    chk("t4_ovr_clr", 32'(overrun), 0);
    ev_ready = 1'b1;
    @(negedge clk);
    chk("t5_accept", 32'(ev_valid), 0);
    repeat (5) @(negedge clk);
    chk("t4_count", 32'(ev_q.size()), 2);
    chk("t4_first", 32'(ev_q[0]), 32'(3'b001));
    chk("t4_pol", 32'(ev_q[1]), 32'(3'b100));
    // async reset while presenting ch3
    ev_ready = 1'b0;
    raw_in[3] = 1'b1;
    wait_valid("t6_valid");
    chk("t6_ev", 32'({ev_ch, ev_rise}), 32'(3'b111));
    chk("t6_level_pre", 32'(level_out), 32'(4'b1001));
    #2 rst = 1'b0;
    #1;
    chk("t6_valid", 32'(ev_valid), 0);
    chk("t6_level", 32'(level_out), 0);
    chk("t6_irq", 32'(irq), 0);
    chk("t6_ev_clr", 32'({ev_ch, ev_rise}), 0);
    @(negedge clk);
    raw_in = 4'b0000;
    rst = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
